// File: rtl/confreg_pkg.sv
// Shared types and constants for the confreg AXI responder.
package confreg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] BASE_DEF     = 32'h1faf_0000;
  localparam logic [31:0] WIN_MASK_DEF = 32'hffff_0000;

  typedef enum logic {
    R_IDLE,
    R_BEAT
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/confreg_regfile.sv
// NREG x 32 register storage with a strobed write port,
// one async read port and a free-running timer in the top entry.
module confreg_regfile
  import confreg_pkg::*;
#(
  parameter int NREG = 16,
  parameter int IW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic [IW-1:0] ridx,
  output logic [31:0]   rdata,
  output logic [15:0]   led
);

  logic [31:0] regs [NREG];

  // A write to the timer overrides its increment for that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we && widx == IW'(i)) begin
          regs[i] <= strb_merge(regs[i], wdata, wstrb);
        end else if (i == NREG - 1) begin
          regs[i] <= regs[i] + 32'd1;
        end
      end
    end
  end

  assign rdata = regs[ridx];
  assign led   = regs[0][15:0];

endmodule

// File: rtl/axi_confreg_slave.sv
// AXI-subset responder for the uncached confreg window:
// bursting reads, single-address writes, independent channels.
module axi_confreg_slave
  import confreg_pkg::*;
#(
  parameter int          NREG     = 16,
  parameter logic [31:0] BASE     = BASE_DEF,
  parameter logic [31:0] WIN_MASK = WIN_MASK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic [15:0] led
);

  localparam int IW = $clog2(NREG);

  logic unused_ok;
  assign unused_ok = ^arsize;

  rd_state_e rstate, rstate_nx;
  wr_state_e wstate, wstate_nx;

  logic [IW-1:0] ridx, widx, rf_ridx;
  logic [7:0]    cnt, len;
  logic          roor, woor;
  logic [31:0]   rdata_q, rf_rdata;
  logic [1:0]    rresp_q, bresp_q;

  logic [IW-1:0] ar_idx, aw_idx;
  logic          ar_oor, aw_oor;
  logic          ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic          rf_we;

  assign ar_idx = araddr[2 +: IW];
  assign aw_idx = awaddr[2 +: IW];
  assign ar_oor = (araddr & WIN_MASK) != (BASE & WIN_MASK);
  assign aw_oor = (awaddr & WIN_MASK) != (BASE & WIN_MASK);

  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;

  // Read port looks ahead to the next beat's index while bursting.
  assign rf_ridx = (rstate == R_IDLE) ? ar_idx : IW'(ridx + 1'b1);
  assign rf_we   = w_hs & ~woor;

  confreg_regfile #(
    .NREG (NREG)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .widx  (widx),
    .wdata (wdata),
    .wstrb (wstrb),
    .ridx  (rf_ridx),
    .rdata (rf_rdata),
    .led   (led)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rstate <= R_IDLE;
    else     rstate <= rstate_nx;
  end

  always_comb begin
    rstate_nx = rstate;
    unique case (rstate)
      R_IDLE: if (arvalid) rstate_nx = R_BEAT;
      R_BEAT: if (rready && cnt == len) rstate_nx = R_IDLE;
      default: rstate_nx = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (rstate == R_IDLE);
    rvalid  = (rstate == R_BEAT);
    rlast   = rvalid && (cnt == len);
    rdata   = rdata_q;
    rresp   = rresp_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ridx    <= '0;
      cnt     <= '0;
      len     <= '0;
      roor    <= 1'b0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      ridx    <= ar_idx;
      cnt     <= '0;
      len     <= arlen;
      roor    <= ar_oor;
      rdata_q <= ar_oor ? 32'd0 : rf_rdata;
      rresp_q <= ar_oor ? RESP_SLVERR : RESP_OKAY;
    end else if (r_hs && !rlast) begin
      ridx    <= IW'(ridx + 1'b1);
      cnt     <= cnt + 8'd1;
      rdata_q <= roor ? 32'd0 : rf_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wstate <= W_IDLE;
    else     wstate <= wstate_nx;
  end

  always_comb begin
    wstate_nx = wstate;
    unique case (wstate)
      W_IDLE: if (awvalid) wstate_nx = W_DATA;
      W_DATA: if (wvalid && wlast) wstate_nx = W_RESP;
      W_RESP: if (bready) wstate_nx = W_IDLE;
      default: wstate_nx = W_IDLE;
    endcase
  end

  always_comb begin
    awready = (wstate == W_IDLE);
    wready  = (wstate == W_DATA);
    bvalid  = (wstate == W_RESP);
    bresp   = bresp_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx    <= '0;
      woor    <= 1'b0;
      bresp_q <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        widx <= aw_idx;
        woor <= aw_oor;
      end
      if (w_hs && wlast) begin
        bresp_q <= woor ? RESP_SLVERR : RESP_OKAY;
      end else if (b_hs) begin
        bresp_q <= RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi_confreg_slave.sv
// Directed self-checking bench for axi_confreg_slave.
module tb_axi_confreg_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd2;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [15:0] led;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  logic [31:0] bd [16];
  logic [1:0]  br [16];
  logic        bl [16];
  int          bc [16];
  int          stall_bad;

  logic [31:0] t_val;
  int          t_cyc;

  axi_confreg_slave dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .led(led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_write(
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    output logic        bv_now,
    output logic [1:0]  resp,
    output int          wcyc
  );
    int n;
    awaddr = a; awvalid = 1'b1; n = 0;
    while (!awready && n < 20) begin @(posedge clk); #1; n++; end
    if (!awready) begin
      errs++; $display("FAIL aw_timeout got awready=0 exp 1");
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    wdata = d; wstrb = s; wlast = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    wcyc = cyc;
    wvalid = 1'b0; wlast = 1'b0;
    bv_now = bvalid;
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!bvalid) begin
      errs++; $display("FAIL b_timeout got bvalid=0 exp 1");
    end
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(
    input logic [31:0] a,
    input logic [7:0]  l,
    input int          stall_beat
  );
    int n;
    logic [31:0] held;
    stall_bad = 0;
    araddr = a; arlen = l; arvalid = 1'b1; n = 0;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    if (!arready) begin
      errs++; $display("FAIL ar_timeout got arready=0 exp 1");
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    bc[0] = cyc;
    for (int b = 0; b <= int'(l); b++) begin
      n = 0;
      while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
      if (!rvalid) begin
        errs++; $display("FAIL r_timeout beat %0d got rvalid=0 exp 1", b);
      end
      bd[b] = rdata; br[b] = rresp; bl[b] = rlast;
      if (b == stall_beat) begin
        held = rdata;
        repeat (3) begin
          @(posedge clk); #1;
          if (rdata !== held || !rvalid) stall_bad++;
        end
      end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      if (b < 15) bc[b+1] = cyc;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    vecs++; if (arready !== 1'b1 || awready !== 1'b1) begin
      errs++; $display("FAIL rst_ready got %b%b exp 11", arready, awready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    vecs++; if ({rvalid, rlast, wready, bvalid} !== 4'b0000) begin
      errs++; $display("FAIL rst_valids got %b exp 0000",
        {rvalid, rlast, wready, bvalid});
    end
    vecs++; if (rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin
      errs++; $display("FAIL rst_data got %h/%b/%b exp 0/00/00", rdata, rresp, bresp);
    end
    vecs++; if (led !== 16'h0) begin
      errs++; $display("FAIL rst_led got %h exp 0000", led);
    end
    vecs++; if (arready !== 1'b1 || awready !== 1'b1) begin
      errs++; $display("FAIL idle_ready got %b%b exp 11", arready, awready);
    end
  endtask

  task automatic test_write_read;
    logic bv; logic [1:0] rs; int wc;
    do_write(32'h1faf_0004, 32'hdead_beef, 4'b1111, bv, rs, wc);
    vecs++; if (bv !== 1'b1) begin
      errs++; $display("FAIL wr_bvalid_next got %b exp 1", bv);
    end
    vecs++; if (rs !== 2'b00) begin
      errs++; $display("FAIL wr_bresp got %b exp 00", rs);
    end
    do_read(32'h1faf_0004, 8'd0, -1);
    vecs++; if (bd[0] !== 32'hdead_beef) begin
      errs++; $display("FAIL rd_data got %h exp deadbeef", bd[0]);
    end
    vecs++; if (bl[0] !== 1'b1 || br[0] !== 2'b00) begin
      errs++; $display("FAIL rd_last_resp got %b/%b exp 1/00", bl[0], br[0]);
    end
    vecs++; if (rvalid !== 1'b0) begin
      errs++; $display("FAIL rd_done got rvalid=%b exp 0", rvalid);
    end
  endtask

  task automatic test_strobe;
    logic bv; logic [1:0] rs; int wc;
    do_write(32'h1faf_0000, 32'h1122_3344, 4'b1111, bv, rs, wc);
    vecs++; if (led !== 16'h3344) begin
      errs++; $display("FAIL led_full got %h exp 3344", led);
    end
    do_write(32'h1faf_0000, 32'h0000_ab00, 4'b0010, bv, rs, wc);
    vecs++; if (led !== 16'hab44) begin
      errs++; $display("FAIL led_strb got %h exp ab44", led);
    end
    do_read(32'h1faf_0000, 8'd0, -1);
    vecs++; if (bd[0] !== 32'h1122_ab44) begin
      errs++; $display("FAIL strb_data got %h exp 1122ab44", bd[0]);
    end
  endtask

  task automatic test_timer;
    logic bv; logic [1:0] rs; int wc;
    do_write(32'h1faf_003c, 32'h0000_0010, 4'b1111, bv, rs, wc);
    t_val = 32'h10; t_cyc = wc;
    // Write edge E; do_write returns after E+1; AR handshake lands on E+5
    // and samples the value left by E+4, i.e. 0x10 + 4.
    repeat (3) @(posedge clk);
    #1;
    do_read(32'h1faf_003c, 8'd0, -1);
    vecs++; if (bd[0] !== 32'h0000_0014) begin
      errs++; $display("FAIL timer_rd got %h exp 00000014", bd[0]);
    end
    do_write(32'h1faf_003c, 32'h0000_7700, 4'b0010, bv, rs, wc);
    // Strobed merge of old value (0x10 + cycles) with byte1 = 0x77.
    t_val = {16'h0, 8'h77, 8'(32'h10 + (wc - 1 - t_cyc))};
    t_cyc = wc;
    do_read(32'h1faf_003c, 8'd0, -1);
    vecs++; if (bd[0] !== t_val + 32'(bc[0] - 1 - t_cyc)) begin
      errs++; $display("FAIL timer_strb got %h exp %h",
        bd[0], t_val + 32'(bc[0] - 1 - t_cyc));
    end
  endtask

  task automatic test_burst_wrap;
    logic bv; logic [1:0] rs; int wc;
    logic [31:0] exp_d [4];
    do_write(32'h1faf_0038, 32'hcafe_0014, 4'b1111, bv, rs, wc);
    do_read(32'h1faf_0038, 8'd3, 1);
    exp_d[0] = 32'hcafe_0014;
    exp_d[1] = t_val + 32'(bc[1] - 1 - t_cyc);
    exp_d[2] = 32'h1122_ab44;
    exp_d[3] = 32'hdead_beef;
    for (int b = 0; b < 4; b++) begin
      vecs++; if (bd[b] !== exp_d[b] || br[b] !== 2'b00) begin
        errs++; $display("FAIL burst_beat%0d got %h/%b exp %h/00",
          b, bd[b], br[b], exp_d[b]);
      end
      vecs++; if (bl[b] !== (b == 3)) begin
        errs++; $display("FAIL burst_last%0d got %b exp %b", b, bl[b], b == 3);
      end
    end
    vecs++; if (stall_bad !== 0) begin
      errs++; $display("FAIL burst_stall got %0d changes exp 0", stall_bad);
    end
  endtask

  task automatic test_oor;
    logic bv; logic [1:0] rs; int wc;
    do_read(32'h1fb0_0000, 8'd1, -1);
    for (int b = 0; b < 2; b++) begin
      vecs++; if (bd[b] !== 32'h0 || br[b] !== 2'b10 || bl[b] !== (b == 1)) begin
        errs++; $display("FAIL oor_rd%0d got %h/%b/%b exp 0/10/%b",
          b, bd[b], br[b], bl[b], b == 1);
      end
    end
    do_write(32'h1fb0_0000, 32'hffff_ffff, 4'b1111, bv, rs, wc);
    vecs++; if (rs !== 2'b10) begin
      errs++; $display("FAIL oor_bresp got %b exp 10", rs);
    end
    do_read(32'h1faf_0000, 8'd0, -1);
    vecs++; if (bd[0] !== 32'h1122_ab44 || led !== 16'hab44) begin
      errs++; $display("FAIL oor_noupd got %h/%h exp 1122ab44/ab44", bd[0], led);
    end
    do_write(32'h1faf_0008, 32'h0000_0055, 4'b1111, bv, rs, wc);
    vecs++; if (rs !== 2'b00) begin
      errs++; $display("FAIL bresp_clear got %b exp 00", rs);
    end
  endtask

  task automatic test_reset_mid;
    awaddr = 32'h1faf_0008; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    wdata = 32'h1234_5678; wstrb = 4'hf; wlast = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
    araddr = 32'h1faf_0000; arlen = 8'd3; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    vecs++; if (rvalid !== 1'b1 || bvalid !== 1'b1) begin
      errs++; $display("FAIL mid_active got %b%b exp 11", rvalid, bvalid);
    end
    #2 rst = 1'b1;
    #1;
    vecs++; if ({rvalid, bvalid, rlast, wready} !== 4'b0000) begin
      errs++; $display("FAIL mid_drop got %b exp 0000",
        {rvalid, bvalid, rlast, wready});
    end
    vecs++; if (led !== 16'h0) begin
      errs++; $display("FAIL mid_led got %h exp 0000", led);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if ({arready, awready, rvalid, bvalid} !== 4'b1100) begin
      errs++; $display("FAIL post_rst got %b exp 1100",
        {arready, awready, rvalid, bvalid});
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_timer();
    test_burst_wrap();
    test_oor();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
